// File: rtl/pudp_pkg.sv
// rtl/pudp_pkg.sv - shared PUDP framing types, widths and helpers
// Purpose : common definitions for the PUDP encoder/decoder pair.
// Contents: PUDP_TID_W / PUDP_BYTE_W widths, decoder FSM state type,
//           pudp_type_byte() which builds the canonical type byte for a tid.
package pudp_pkg;

    localparam int PUDP_TID_W  = 2;
    localparam int PUDP_BYTE_W = 8;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_FIRST = 2'd1,
        FSM_DATA  = 2'd2
    } pudp_fsm_e;

    // Canonical type byte: channel id in the low bits, everything else zero.
    function automatic logic [PUDP_BYTE_W-1:0] pudp_type_byte(input logic [PUDP_TID_W-1:0] tid);
        return {{(PUDP_BYTE_W-PUDP_TID_W){1'b0}}, tid};
    endfunction

endpackage

// File: rtl/pudp_sat_cnt.sv
// rtl/pudp_sat_cnt.sv - width-parameterised saturating event counter
// Purpose : counts single-cycle increment pulses, sticking at all-ones.
// Ports   : clki/rstni clock and async active-low reset,
//           inc_i increment pulse, count_o current count.
module pudp_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clki,
    input  logic             rstni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clki or negedge rstni) begin
        if (!rstni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pudp_decode.sv
// rtl/pudp_decode.sv - PUDP receive-side deframer with checksum check
// Purpose : strips [type][data..][checksum,tlast] framing, emits payload on an
//           AXI-Stream master with tid, flags bad frames via tuser on tlast.
// Ports   : clki/rstni           clock, async active-low reset
//           s_axis_*             framed byte stream in (tdata/tvalid/tready/tlast)
//           m_axis_*             payload out (tdata/tvalid/tready/tlast/tid/tuser)
//           frame_ok/frame_err   one-cycle per-frame status pulses
//           ok_cnt/err_cnt       saturating good/bad frame counts
module pudp_decode
    import pudp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clki,
    input  logic                   rstni,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    input  logic [PUDP_BYTE_W-1:0] s_axis_tdata,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    output logic [PUDP_BYTE_W-1:0] m_axis_tdata,
    output logic [PUDP_TID_W-1:0]  m_axis_tid,
    output logic                   m_axis_tuser,
    output logic                   frame_ok,
    output logic                   frame_err,
    output logic [CNT_W-1:0]       ok_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    pudp_fsm_e              state_q, state_d;
    logic [PUDP_BYTE_W-1:0] hold_q, hold_d;
    logic [PUDP_BYTE_W-1:0] chk_q, chk_d;
    logic [PUDP_TID_W-1:0]  tid_q, tid_d;
    logic                   bad_type_q, bad_type_d;

    logic                   mv_q, mv_d;
    logic                   mlast_q, mlast_d;
    logic                   muser_q, muser_d;
    logic [PUDP_BYTE_W-1:0] mdata_q, mdata_d;
    logic [PUDP_TID_W-1:0]  mtid_q, mtid_d;

    logic                   ok_q, ok_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic                   frame_bad;

    // Only the DATA state loads the output register, so IDLE/FIRST may keep
    // accepting while a previous frame's last beat is stalled downstream.
    assign s_axis_tready = (state_q != FSM_DATA) | ~mv_q | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign frame_bad     = ((chk_q ^ s_axis_tdata) != '0) | bad_type_q;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        chk_d      = chk_q;
        tid_d      = tid_q;
        bad_type_d = bad_type_q;
        mv_d       = mv_q;
        mlast_d    = mlast_q;
        muser_d    = muser_q;
        mdata_d    = mdata_q;
        mtid_d     = mtid_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;

        if (mv_q && m_axis_tready) begin
            mv_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                FSM_IDLE: begin
                    if (s_axis_tlast) begin
                        err_d = 1'b1;
                    end else begin
                        tid_d      = s_axis_tdata[PUDP_TID_W-1:0];
                        chk_d      = s_axis_tdata;
                        bad_type_d = (s_axis_tdata != pudp_type_byte(s_axis_tdata[PUDP_TID_W-1:0]));
                        state_d    = FSM_FIRST;
                    end
                end
                FSM_FIRST: begin
                    if (s_axis_tlast) begin
                        err_d   = 1'b1;
                        state_d = FSM_IDLE;
                    end else begin
                        hold_d  = s_axis_tdata;
                        chk_d   = chk_q ^ s_axis_tdata;
                        state_d = FSM_DATA;
                    end
                end
                FSM_DATA: begin
                    // The held byte is released now that we know whether the
                    // current beat is the checksum.
                    mv_d    = 1'b1;
                    mdata_d = hold_q;
                    mtid_d  = tid_q;
                    if (s_axis_tlast) begin
                        mlast_d = 1'b1;
                        muser_d = frame_bad;
                        ok_d    = ~frame_bad;
                        err_d   = frame_bad;
                        state_d = FSM_IDLE;
                    end else begin
                        mlast_d = 1'b0;
                        muser_d = 1'b0;
                        hold_d  = s_axis_tdata;
                        chk_d   = chk_q ^ s_axis_tdata;
                    end
                end
                default: begin
                    state_d = FSM_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clki or negedge rstni) begin
        if (!rstni) begin
            state_q    <= FSM_IDLE;
            hold_q     <= '0;
            chk_q      <= '0;
            tid_q      <= '0;
            bad_type_q <= 1'b0;
            mv_q       <= 1'b0;
            mlast_q    <= 1'b0;
            muser_q    <= 1'b0;
            mdata_q    <= '0;
            mtid_q     <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            chk_q      <= chk_d;
            tid_q      <= tid_d;
            bad_type_q <= bad_type_d;
            mv_q       <= mv_d;
            mlast_q    <= mlast_d;
            muser_q    <= muser_d;
            mdata_q    <= mdata_d;
            mtid_q     <= mtid_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    // Counters advance on the same edge that raises the matching pulse.
    pudp_sat_cnt #(.WIDTH(CNT_W)) u_ok_cnt (
        .clki    (clki),
        .rstni   (rstni),
        .inc_i   (ok_d),
        .count_o (ok_cnt)
    );

    pudp_sat_cnt #(.WIDTH(CNT_W)) u_err_cnt (
        .clki    (clki),
        .rstni   (rstni),
        .inc_i   (err_d),
        .count_o (err_cnt)
    );

    assign m_axis_tvalid = mv_q;
    assign m_axis_tlast  = mlast_q;
    assign m_axis_tuser  = muser_q;
    assign m_axis_tdata  = mdata_q;
    assign m_axis_tid    = mtid_q;
    assign frame_ok      = ok_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_pudp_decode.sv
// tb/tb_pudp_decode.sv - self-checking bench for pudp_decode
module tb_pudp_decode;

    logic       clk = 1'b0;
    logic       rstn;
    logic       s_tvalid, s_tlast, s_tready;
    logic [7:0] s_tdata;
    logic       m_ready;
    logic       m_tvalid, m_tlast, m_tuser;
    logic [7:0] m_tdata;
    logic [1:0] m_tid;
    logic       frame_ok, frame_err;
    logic [15:0] ok_cnt, err_cnt;

    logic       s_tready2, m_tvalid2, m_tlast2, m_tuser2, frame_ok2, frame_err2;
    logic [7:0] m_tdata2;
    logic [1:0] m_tid2;
    logic [1:0] ok_cnt2, err_cnt2;

    always #5 clk = ~clk;

    pudp_decode #(.CNT_W(16)) dut (
        .clki(clk), .rstni(rstn),
        .s_axis_tready(s_tready), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata),
        .m_axis_tready(m_ready), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tdata(m_tdata),
        .m_axis_tid(m_tid), .m_axis_tuser(m_tuser),
        .frame_ok(frame_ok), .frame_err(frame_err), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
    );

    pudp_decode #(.CNT_W(2)) dut_sat (
        .clki(clk), .rstni(rstn),
        .s_axis_tready(s_tready2), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata),
        .m_axis_tready(m_ready), .m_axis_tvalid(m_tvalid2), .m_axis_tlast(m_tlast2), .m_axis_tdata(m_tdata2),
        .m_axis_tid(m_tid2), .m_axis_tuser(m_tuser2),
        .frame_ok(frame_ok2), .frame_err(frame_err2), .ok_cnt(ok_cnt2), .err_cnt(err_cnt2)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic [1:0] tid;
    } beat_t;

    beat_t obs_q[$];
    beat_t exp_q[$];
    int    pass_cnt  = 0;
    int    total_cnt = 0;
    int    ok_pulses = 0;
    int    err_pulses = 0;
    int    misalign = 0;
    int    exp_ok = 0;
    int    exp_err = 0;
    bit    rand_rdy = 1'b0;

    // Output monitor: a beat transfers on the next rising edge when valid&ready.
    always @(negedge clk) begin
        beat_t b;
        if (rstn && m_tvalid && m_ready) begin
            b.data = m_tdata; b.last = m_tlast; b.user = m_tuser; b.tid = m_tid;
            obs_q.push_back(b);
        end
        if (frame_ok) begin
            ok_pulses++;
            if (!(m_tvalid && m_tlast && !m_tuser)) misalign++;
        end
        if (frame_err) err_pulses++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit got = 1'b0;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            got = s_tready;
            @(posedge clk);
            #1;
            if (got) break;
        end
        s_tvalid = 1'b0;
        if (!got) begin
            total_cnt++;
            $display("FAIL send_byte timeout: accepted=0 required=1 byte=%02h", d);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l, input logic u, input logic [1:0] t);
        beat_t b;
        b.data = d; b.last = l; b.user = u; b.tid = t;
        exp_q.push_back(b);
    endtask

    function automatic int count_mismatch();
        int n = 0;
        if (obs_q.size() != exp_q.size()) return -1;
        foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic clear_q();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rstn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata, m_tid} !== 13'h0) $display("FAIL reset_outputs: got %h required 0", {m_tvalid, m_tlast, m_tuser, m_tdata, m_tid});
        else pass_cnt++;
        total_cnt++;
        if ({ok_cnt, err_cnt, frame_ok, frame_err} !== 34'h0) $display("FAIL reset_counters: ok=%0d err=%0d required 0", ok_cnt, err_cnt);
        else pass_cnt++;
        total_cnt++;
        if (s_tready !== 1'b1) $display("FAIL reset_tready: got %b required 1", s_tready);
        else pass_cnt++;
        @(posedge clk); #1; rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_good_frame();
        int p0 = ok_pulses;
        int mm;
        clear_q();
        send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h02, 1);
        push_exp(8'h11, 0, 0, 2); push_exp(8'h22, 0, 0, 2); push_exp(8'h33, 1, 0, 2);
        exp_ok++;
        repeat (4) @(posedge clk); #1;
        mm = count_mismatch();
        total_cnt++;
        if (mm != 0) $display("FAIL good_beats: got %0d beats (mismatch %0d) required %0d", obs_q.size(), mm, exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (ok_pulses - p0 != 1 || ok_cnt !== 16'(exp_ok)) $display("FAIL good_ok: pulses=%0d cnt=%0d required 1/%0d", ok_pulses - p0, ok_cnt, exp_ok);
        else pass_cnt++;
        total_cnt++;
        if (misalign != 0) $display("FAIL ok_pulse_align: got %0d misaligned required 0", misalign);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int mm;
        clear_q();
        send_byte(8'h01, 0); send_byte(8'hAA, 0); send_byte(8'hAB, 1);
        push_exp(8'hAA, 1, 0, 1);
        exp_ok++;
        repeat (4) @(posedge clk); #1;
        mm = count_mismatch();
        total_cnt++;
        if (mm != 0) $display("FAIL single_beat: got %0d beats (mismatch %0d) required 1", obs_q.size(), mm);
        else pass_cnt++;
        total_cnt++;
        if (ok_cnt !== 16'(exp_ok)) $display("FAIL single_ok_cnt: got %0d required %0d", ok_cnt, exp_ok);
        else pass_cnt++;
    endtask

    task automatic test_bad_checksum();
        int e0 = err_pulses;
        int mm;
        clear_q();
        send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h03, 1);
        push_exp(8'h11, 0, 0, 2); push_exp(8'h22, 0, 0, 2); push_exp(8'h33, 1, 1, 2);
        exp_err++;
        repeat (4) @(posedge clk); #1;
        mm = count_mismatch();
        total_cnt++;
        if (mm != 0) $display("FAIL badchk_beats: got %0d beats (mismatch %0d) required 3", obs_q.size(), mm);
        else pass_cnt++;
        total_cnt++;
        if (err_pulses - e0 != 1 || err_cnt !== 16'(exp_err) || ok_cnt !== 16'(exp_ok))
            $display("FAIL badchk_cnt: pulses=%0d err=%0d ok=%0d required 1/%0d/%0d", err_pulses - e0, err_cnt, ok_cnt, exp_err, exp_ok);
        else pass_cnt++;
    endtask

    task automatic test_runt_empty();
        int e0 = err_pulses;
        int mm;
        clear_q();
        send_byte(8'h05, 1);
        send_byte(8'h01, 0); send_byte(8'h01, 1);
        exp_err += 2;
        repeat (4) @(posedge clk); #1;
        total_cnt++;
        if (obs_q.size() != 0 || err_cnt !== 16'(exp_err) || err_pulses - e0 != 2)
            $display("FAIL runt_empty: beats=%0d err=%0d pulses=%0d required 0/%0d/2", obs_q.size(), err_cnt, err_pulses - e0, exp_err);
        else pass_cnt++;
        send_byte(8'h03, 0); send_byte(8'h7E, 0); send_byte(8'h7D, 1);
        push_exp(8'h7E, 1, 0, 3);
        exp_ok++;
        repeat (4) @(posedge clk); #1;
        mm = count_mismatch();
        total_cnt++;
        if (mm != 0 || ok_cnt !== 16'(exp_ok)) $display("FAIL after_runt: beats=%0d mismatch=%0d ok=%0d required 1/0/%0d", obs_q.size(), mm, ok_cnt, exp_ok);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        int mm;
        clear_q();
        send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
        m_ready = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 8'h11)
            $display("FAIL bp_stall: tready=%b tvalid=%b tdata=%02h required 0/1/11", s_tready, m_tvalid, m_tdata);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 8'h11 || m_tlast !== 1'b0 || m_tid !== 2'd2) unstable++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (unstable != 0) $display("FAIL bp_hold: got %0d unstable cycles required 0", unstable);
        else pass_cnt++;
        m_ready = 1'b1;
        send_byte(8'h33, 0); send_byte(8'h02, 1);
        push_exp(8'h11, 0, 0, 2); push_exp(8'h22, 0, 0, 2); push_exp(8'h33, 1, 0, 2);
        exp_ok++;
        repeat (4) @(posedge clk); #1;
        mm = count_mismatch();
        total_cnt++;
        if (mm != 0) $display("FAIL bp_beats: got %0d beats (mismatch %0d) required 3", obs_q.size(), mm);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int mm;
        int kind, len;
        logic [7:0] ty, chk, d;
        logic [1:0] tid;
        logic bad, corrupt;
        logic [7:0] pay[$];
        clear_q();
        misalign = 0;
        rand_rdy = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            tid  = 2'($urandom_range(0, 3));
            bad  = ($urandom_range(0, 15) == 0);
            ty   = {6'b0, tid} | (bad ? 8'h40 : 8'h00);
            kind = $urandom_range(0, 19);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            if (kind == 0) begin
                send_byte(ty, 1);
                exp_err++;
            end else if (kind == 1) begin
                send_byte(ty, 0);
                send_byte(8'($urandom), 1);
                exp_err++;
            end else begin
                len = $urandom_range(1, 5);
                pay.delete();
                chk = ty;
                send_byte(ty, 0);
                for (int i = 0; i < len; i++) begin
                    d = 8'($urandom);
                    pay.push_back(d);
                    chk ^= d;
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    send_byte(d, 0);
                end
                corrupt = ($urandom_range(0, 7) == 0);
                if (corrupt) chk ^= 8'h01;
                send_byte(chk, 1);
                for (int i = 0; i < len; i++) push_exp(pay[i], (i == len - 1), (i == len - 1) ? (bad | corrupt) : 1'b0, tid);
                if (bad | corrupt) exp_err++;
                else exp_ok++;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        m_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (obs_q.size() >= exp_q.size() && !m_tvalid) break;
        end
        repeat (2) @(posedge clk); #1;
        mm = count_mismatch();
        total_cnt++;
        if (mm != 0) $display("FAIL random_beats: got %0d beats (mismatch %0d) required %0d", obs_q.size(), mm, exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err))
            $display("FAIL random_counts: ok=%0d err=%0d required %0d/%0d", ok_cnt, err_cnt, exp_ok, exp_err);
        else pass_cnt++;
        total_cnt++;
        if (misalign != 0) $display("FAIL random_pulse_align: got %0d required 0", misalign);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        int mm;
        send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
        m_ready = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        total_cnt++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata, m_tid} !== 13'h0 || ok_cnt !== 16'h0 || err_cnt !== 16'h0)
            $display("FAIL async_reset: out=%h ok=%0d err=%0d required 0", {m_tvalid, m_tlast, m_tuser, m_tdata, m_tid}, ok_cnt, err_cnt);
        else pass_cnt++;
        @(posedge clk); #1;
        rstn = 1'b1;
        m_ready = 1'b1;
        clear_q();
        exp_ok = 0; exp_err = 0;
        send_byte(8'h01, 0); send_byte(8'hAA, 0); send_byte(8'hAB, 1);
        push_exp(8'hAA, 1, 0, 1);
        exp_ok++;
        repeat (4) @(posedge clk); #1;
        mm = count_mismatch();
        total_cnt++;
        if (mm != 0 || ok_cnt !== 16'd1) $display("FAIL post_reset_frame: beats=%0d mismatch=%0d ok=%0d required 1/0/1", obs_q.size(), mm, ok_cnt);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) send_byte(8'h05, 1);
        repeat (3) @(posedge clk); #1;
        total_cnt++;
        if (err_cnt2 !== 2'd3) $display("FAIL sat_err_cnt: got %0d required 3", err_cnt2);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt !== 16'd5) $display("FAIL wide_err_cnt: got %0d required 5", err_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_single();
        test_bad_checksum();
        test_runt_empty();
        test_backpressure();
        test_random();
        test_reset_midframe();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pudp_decode.md
Name: pudp_decode

Overview:
- Receive-side counterpart of the PUDP framer.
- Consumes a byte stream framed as [type byte][≥1 data bytes][checksum byte, tlast], where type = {6'b0, tid} and checksum = XOR of the type byte and all data bytes.
- Strips the type and checksum bytes, presents the payload on an AXI-Stream master with tid, and marks the last payload byte with tlast plus a tuser error flag.
- Sits between the Ethernet/UDP receive path and the per-channel consumers.

Parameters:
- CNT_W, 16, width of the saturating good-frame and bad-frame counters.

Ports:
- clki  in  1  clock
- rstni  in  1  asynchronous active-low reset
- s_axis_tready  out  1  upstream ready
- s_axis_tvalid  in  1  upstream valid
- s_axis_tlast  in  1  marks the checksum byte
- s_axis_tdata  in  8  framed byte stream
- m_axis_tready  in  1  downstream ready
- m_axis_tvalid  out  1  payload valid
- m_axis_tlast  out  1  last payload byte of the frame
- m_axis_tdata  out  8  payload byte
- m_axis_tid  out  2  channel id from the type byte, stable for the whole frame
- m_axis_tuser  out  1  frame error; meaningful only when tlast=1
- frame_ok  out  1  one-cycle pulse per good frame
- frame_err  out  1  one-cycle pulse per bad, runt or empty frame
- ok_cnt  out  CNT_W  saturating good-frame count
- err_cnt  out  CNT_W  saturating bad-frame count

Behaviour:
- Reset (rstni=0, asynchronous):
  - fsm=IDLE; hold, chk, tid_reg and bad_type cleared.
  - All outputs 0, counters 0.
  - A frame in progress is discarded. After release, the first accepted byte is treated as a type byte.
- Input handshake:
  - s_axis_tready = (fsm!=DATA) | !m_axis_tvalid | m_axis_tready.
  - A beat is accepted when s_axis_tvalid & s_axis_tready.
- Output register:
  - One registered beat: m_axis_tvalid/tdata/tlast/tuser/tid.
  - Cleared on m_axis_tvalid & m_axis_tready unless reloaded in the same cycle.
  - Data/tid/last/user are held stable while valid=1 and ready=0.
- One-byte lookahead:
  - Each payload byte is held in `hold` until the next beat shows whether that beat is the checksum.
  - Latency: a payload byte appears on m_axis 1 cycle after the following input beat is accepted.
- FSM, actions on accepted beats only:
  - IDLE:
    - If tlast: runt frame. Pulse frame_err, err_cnt++, stay IDLE, no output.
    - Else: tid_reg<=tdata[1:0], chk<=tdata, bad_type<=(tdata[7:2]!=0), go to FIRST.
  - FIRST:
    - If tlast: empty frame. Pulse frame_err, err_cnt++, go to IDLE, no output.
    - Else: hold<=tdata, chk<=chk^tdata, go to DATA.
  - DATA, not tlast:
    - Output {hold, last=0, user=0, tid=tid_reg}.
    - hold<=tdata, chk<=chk^tdata, stay DATA.
  - DATA, tlast:
    - err = ((chk^tdata)!=0) | bad_type.
    - Output {hold, last=1, user=err, tid=tid_reg}.
    - Pulse frame_ok (err=0) or frame_err (err=1); increment the matching counter. Go to IDLE.
- Pulse timing: frame_ok/frame_err are registered and assert in the same cycle m_axis_tvalid rises with tlast.
- Counters: saturate at 2^CNT_W-1 and never wrap.
- Back-to-back frames: a type byte may be accepted in IDLE while the previous frame's last beat is still stalled on m_axis. That beat is not disturbed; m_axis_tid changes only when the next payload beat is loaded.
- Upstream stalls (tvalid low mid-frame) are tolerated in any state with no timeout.

Decomposition:
- pudp_pkg:
  - fsm enum {IDLE, FIRST, DATA}.
  - PUDP_TID_W=2, PUDP_BYTE_W=8.
  - Shared with pudp_encode for future use.
- One sub-module, pudp_sat_cnt (width-parameterised saturating counter with an increment pulse), instantiated twice.

Test Plan:
- Good multi-byte frame: stream 02 11 22 33 02(last), m_axis_tready=1 → out 11, 22, 33(last, tuser=0), tid=2 on every beat. frame_ok pulses once, ok_cnt=1.
- Single payload byte: 01 AA AB(last) → one beat AA, tlast=1, tuser=0, tid=1. ok_cnt increments.
- Bad checksum: 02 11 22 33 03(last) → 33 carries tlast=1, tuser=1. frame_err pulses, err_cnt=1, ok_cnt unchanged.
- Runt and empty frames:
  - 05(last) → no m_axis beats, err_cnt+1.
  - 01 01(last) → no m_axis beats, err_cnt+1.
  - The following good frame 03 7E 7D(last) decodes correctly with tid=3.
- Backpressure: hold m_axis_tready=0 for 3 cycles mid-frame → s_axis_tready drops within 1 cycle, the output beat stays stable, and no bytes are lost or duplicated. Scoreboard matches the encoder's golden model over 1000 random frames with random tready/tvalid.
- Reset mid-frame and saturation:
  - Drop rstni after 02 11 → all outputs 0 immediately; the next frame 01 AA AB decodes cleanly.
  - With CNT_W=2, send 5 bad frames → err_cnt holds at 3.
